// File: rtl/call_request_unit.sv
// Purpose: debounce four floor-call switches, track pending/issued floor calls and offer the nearest one.
// Latency: switch edge -> debounced 2+DB_CYCLES cycles; debounced rise -> pending 1 cycle; pending -> req_valid 1 cycle.
// Backpressure: an offer holds req_floor stable until req_ready accepts it or a serve of that floor withdraws it.
module call_request_unit #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] SW,
  input  logic [1:0] cur_floor,
  input  logic       serve_valid,
  input  logic [1:0] serve_floor,
  output logic       req_valid,
  output logic [1:0] req_floor,
  input  logic       req_ready,
  output logic [7:0] LED
);

  localparam int unsigned   CW      = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  // Switch synchronizer and debounce state
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_db;
  logic [3:0]    r_db_d;
  logic [CW-1:0] r_cnt [4];

  // Request tracking
  logic [3:0] r_pending;
  logic [3:0] r_issued;

  // Offer FSM
  state_t     r_state;
  logic       r_req_valid;
  logic [1:0] r_req_floor;

  // Combinational helpers
  logic [3:0] w_rise;
  logic [3:0] w_clr;
  logic [3:0] w_iss_set;
  logic [3:0] w_cand;
  logic       w_withdraw;
  logic       w_accept;
  logic       w_found;
  logic [1:0] w_best;
  logic [1:0] w_best_dist;
  logic [1:0] w_dist;

  // Two-flop synchronizer on the raw switches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= SW;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit debounce: the debounced value flips only after DB_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_db   <= '0;
      r_db_d <= '0;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_db_d <= r_db;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_cnt[i] <= '0;
          r_db[i]  <= ~r_db[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Only a debounced 0->1 edge registers a call; releases and held levels are ignored
  assign w_rise = r_db & ~r_db_d;

  // A serve pulse clears its floor; an accepted offer marks its floor issued
  assign w_clr      = serve_valid ? (4'b0001 << serve_floor) : 4'b0000;
  assign w_withdraw = r_req_valid && serve_valid && (serve_floor == r_req_floor);
  assign w_accept   = r_req_valid && req_ready && !w_withdraw;
  assign w_iss_set  = w_accept ? (4'b0001 << r_req_floor) : 4'b0000;

  // Nearest-floor pick among unissued pending calls; strict compare in ascending order favours the lower floor on ties.
  // Floors being served this cycle are excluded so an offer never starts for a floor about to be cleared.
  always_comb begin
    w_cand      = r_pending & ~r_issued & ~w_clr;
    w_found     = 1'b0;
    w_best      = 2'd0;
    w_best_dist = 2'd3;
    w_dist      = 2'd0;
    for (int f = 0; f < 4; f++) begin
      w_dist = (2'(f) >= cur_floor) ? (2'(f) - cur_floor) : (cur_floor - 2'(f));
      if (w_cand[f] && (!w_found || (w_dist < w_best_dist))) begin
        w_found     = 1'b1;
        w_best      = 2'(f);
        w_best_dist = w_dist;
      end
    end
  end

  // Pending/issued bookkeeping: a new press beats a same-cycle serve for pending, while issued always clears on serve
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_issued  <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_rise;
      r_issued  <= (r_issued | w_iss_set) & ~w_clr;
    end
  end

  // Offer FSM: latch the chosen floor in IDLE, hold it in OFFER until accepted or withdrawn
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req_valid <= 1'b0;
      r_req_floor <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state     <= ST_OFFER;
            r_req_valid <= 1'b1;
            r_req_floor <= w_best;
          end
        end
        ST_OFFER: begin
          if (w_withdraw || w_accept) begin
            r_state     <= ST_IDLE;
            r_req_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_valid = r_req_valid;
  assign req_floor = r_req_floor;
  assign LED       = {r_issued, r_pending};

endmodule

// File: tb/tb_call_request_unit.sv
// Purpose: directed checks of call_request_unit with a short debounce window.
// Latency: inputs change 1 time unit after a rising edge and outputs are sampled at that same point.
// Backpressure: req_ready is driven explicitly per scenario.
module tb_call_request_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] SW;
  logic [1:0] cur_floor;
  logic       serve_valid;
  logic [1:0] serve_floor;
  logic       req_valid;
  logic [1:0] req_floor;
  logic       req_ready;
  logic [7:0] LED;

  int n_vec;
  int n_err;

  call_request_unit #(.DB_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .SW         (SW),
    .cur_floor  (cur_floor),
    .serve_valid(serve_valid),
    .serve_floor(serve_floor),
    .req_valid  (req_valid),
    .req_floor  (req_floor),
    .req_ready  (req_ready),
    .LED        (LED)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    SW          = 4'b0000;
    serve_valid = 1'b0;
    serve_floor = 2'd0;
    req_ready   = 1'b0;
    rst_n       = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cur_floor = 2'd0;
    do_reset();
    n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0h expected 0", req_valid); end
    n_vec++; if (req_floor !== 2'd0) begin n_err++; $display("FAIL reset_floor: got %0h expected 0", req_floor); end
    n_vec++; if (LED !== 8'h00) begin n_err++; $display("FAIL reset_led: got %0h expected 00", LED); end
  endtask

  task automatic test_basic_offer();
    do_reset();
    cur_floor = 2'd0;
    SW = 4'b0001;
    repeat (6) tick();
    n_vec++; if (LED !== 8'h00) begin n_err++; $display("FAIL basic_pend_c6: got %0h expected 00", LED); end
    tick();
    n_vec++; if (LED !== 8'h01) begin n_err++; $display("FAIL basic_pend_c7: got %0h expected 01", LED); end
    n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_c7: got %0h expected 0", req_valid); end
    tick();
    n_vec++; if (req_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid_c8: got %0h expected 1", req_valid); end
    n_vec++; if (req_floor !== 2'd0) begin n_err++; $display("FAIL basic_floor_c8: got %0h expected 0", req_floor); end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    n_vec++; if (LED !== 8'h11) begin n_err++; $display("FAIL basic_led_accept: got %0h expected 11", LED); end
    n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_accept: got %0h expected 0", req_valid); end
    tick();
    n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL basic_no_reoffer: got %0h expected 0", req_valid); end
  endtask

  task automatic test_glitch();
    do_reset();
    cur_floor = 2'd0;
    SW = 4'b0100;
    repeat (3) tick();
    SW = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if ({req_valid, LED} !== 9'h000) begin
        n_err++; $display("FAIL glitch_cycle%0d: got valid=%0h led=%0h expected valid=0 led=00", i, req_valid, LED);
      end
    end
  endtask

  task automatic test_tie_lower();
    do_reset();
    cur_floor = 2'd2;
    SW = 4'b1010;
    repeat (7) tick();
    n_vec++; if (LED !== 8'h0A) begin n_err++; $display("FAIL tie_pending: got %0h expected 0a", LED); end
    tick();
    n_vec++; if (req_valid !== 1'b1) begin n_err++; $display("FAIL tie_valid: got %0h expected 1", req_valid); end
    n_vec++; if (req_floor !== 2'd1) begin n_err++; $display("FAIL tie_floor: got %0h expected 1", req_floor); end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL tie_gap: got %0h expected 0", req_valid); end
    n_vec++; if (LED !== 8'h2A) begin n_err++; $display("FAIL tie_led_accept: got %0h expected 2a", LED); end
    tick();
    n_vec++; if (req_valid !== 1'b1) begin n_err++; $display("FAIL tie_second_valid: got %0h expected 1", req_valid); end
    n_vec++; if (req_floor !== 2'd3) begin n_err++; $display("FAIL tie_second_floor: got %0h expected 3", req_floor); end
    tick();
    n_vec++; if (req_floor !== 2'd3) begin n_err++; $display("FAIL tie_floor_stable: got %0h expected 3", req_floor); end
  endtask

  // Continues from test_tie_lower: floor 3 is on offer, floor 1 already issued
  task automatic test_serve_withdraw();
    serve_valid = 1'b1;
    serve_floor = 2'd3;
    req_ready   = 1'b1;
    tick();
    serve_valid = 1'b0;
    req_ready   = 1'b0;
    n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL withdraw_valid: got %0h expected 0", req_valid); end
    n_vec++; if (LED !== 8'h22) begin n_err++; $display("FAIL withdraw_led: got %0h expected 22", LED); end
    tick();
    n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL withdraw_stays_idle: got %0h expected 0", req_valid); end
  endtask

  task automatic test_nearest_far();
    do_reset();
    cur_floor = 2'd3;
    SW = 4'b0101;
    repeat (8) tick();
    n_vec++; if (req_valid !== 1'b1) begin n_err++; $display("FAIL near_valid: got %0h expected 1", req_valid); end
    n_vec++; if (req_floor !== 2'd2) begin n_err++; $display("FAIL near_floor: got %0h expected 2", req_floor); end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    n_vec++; if (LED !== 8'h45) begin n_err++; $display("FAIL near_led: got %0h expected 45", LED); end
    tick();
    n_vec++; if (req_floor !== 2'd0) begin n_err++; $display("FAIL near_second_floor: got %0h expected 0", req_floor); end
    n_vec++; if (req_valid !== 1'b1) begin n_err++; $display("FAIL near_second_valid: got %0h expected 1", req_valid); end
  endtask

  task automatic test_rise_with_serve();
    do_reset();
    cur_floor = 2'd0;
    SW = 4'b0001;
    repeat (8) tick();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    n_vec++; if (LED !== 8'h11) begin n_err++; $display("FAIL rs_issued: got %0h expected 11", LED); end
    SW = 4'b0000;
    repeat (8) tick();
    n_vec++; if ({req_valid, LED} !== 9'h011) begin n_err++; $display("FAIL rs_release: got valid=%0h led=%0h expected valid=0 led=11", req_valid, LED); end
    SW = 4'b0001;
    repeat (6) tick();
    serve_valid = 1'b1;
    serve_floor = 2'd0;
    tick();
    serve_valid = 1'b0;
    n_vec++; if (LED !== 8'h01) begin n_err++; $display("FAIL rs_led: got %0h expected 01", LED); end
    n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL rs_valid_same: got %0h expected 0", req_valid); end
    tick();
    n_vec++; if (req_valid !== 1'b1) begin n_err++; $display("FAIL rs_reoffer_valid: got %0h expected 1", req_valid); end
    n_vec++; if (req_floor !== 2'd0) begin n_err++; $display("FAIL rs_reoffer_floor: got %0h expected 0", req_floor); end
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    cur_floor = 2'd0;
    SW = 4'b1111;
    repeat (8) tick();
    n_vec++; if (req_valid !== 1'b1) begin n_err++; $display("FAIL rm_valid_pre: got %0h expected 1", req_valid); end
    n_vec++; if (LED !== 8'h0F) begin n_err++; $display("FAIL rm_led_pre: got %0h expected 0f", LED); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid_rst: got %0h expected 0", req_valid); end
    n_vec++; if (LED !== 8'h00) begin n_err++; $display("FAIL rm_led_rst: got %0h expected 00", LED); end
    repeat (6) tick();
    n_vec++; if (LED !== 8'h00) begin n_err++; $display("FAIL rm_led_c6: got %0h expected 00", LED); end
    tick();
    n_vec++; if (LED !== 8'h0F) begin n_err++; $display("FAIL rm_led_c7: got %0h expected 0f", LED); end
    tick();
    n_vec++; if (req_valid !== 1'b1) begin n_err++; $display("FAIL rm_reoffer_valid: got %0h expected 1", req_valid); end
    n_vec++; if (req_floor !== 2'd0) begin n_err++; $display("FAIL rm_reoffer_floor: got %0h expected 0", req_floor); end
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    SW          = 4'b0000;
    cur_floor   = 2'd0;
    serve_valid = 1'b0;
    serve_floor = 2'd0;
    req_ready   = 1'b0;
    test_reset();
    test_basic_offer();
    test_glitch();
    test_tie_lower();
    test_serve_withdraw();
    test_nearest_far();
    test_rise_with_serve();
    test_reset_mid_offer();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
